regfile8_32: RTL and testbench
==============================

Name: regfile8_32

Overview:
- 8-entry x 32-bit register file for the project datapath; sits directly upstream of the 32-bit 8:1 mux (mux8_32) and supplies its eight 32-bit data inputs.
- One synchronous write port and two combinational read ports.
- Each read port is an instance of mux8_32 selected by a 3-bit read address.
- Optional register-0-hardwired-zero and write-to-read bypass behaviour.

Parameters:
- ZERO_REG, 1, 1 = register 0 always reads 32'h00000000 and writes to address 0 are discarded; 0 = register 0 is an ordinary register.
- BYPASS, 1, 1 = a read of the address being written in the same cycle returns wd; 0 = the read returns the old stored value until after the clock edge.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous, active-low reset
- we  input  1  write enable, sampled on rising clk
- wa  input  3  write address
- wd  input  32  write data
- ra0  input  3  read address, port 0
- ra1  input  3  read address, port 1
- rd0  output  32  read data, port 0 (combinational from ra0 and state)
- rd1  output  32  read data, port 1 (combinational from ra1 and state)

Behaviour:
- Storage: r0..r7, 32 bits each.
- Reset: rst_n low clears r0..r7 to 32'h00000000 immediately, without waiting for clk.
  - While rst_n is low, rd0 = rd1 = 32'h00000000 for any address.
  - we is ignored while rst_n is low.
- Reset release: the first write takes effect at the first rising clk with rst_n high.
- Reset mid-operation: asserting rst_n between edges clears all registers at once. A write pending on the next edge is lost if rst_n is still low at that edge.
- Write:
  - At rising clk, if rst_n=1 and we=1, r[wa] <= wd.
  - If ZERO_REG=1 and wa=0, the write is dropped and r0 stays 0.
  - we=0: no register changes.
- Read:
  - rd0 = r[ra0] and rd1 = r[ra1], zero-latency combinational.
  - Each port drives mux8_32 with i0..i7 = r0..r7 and s = raN, so a read reflects a write on the same cycle as the clock edge.
- Bypass (BYPASS=1):
  - If we=1, rst_n=1, raN==wa and the write is not dropped, rdN = wd.
  - The override is combinational and applies in the same cycle.
  - A dropped write (ZERO_REG=1, wa=0) does not bypass; rdN reads 0.
- Simultaneous events:
  - Both ports may read the same address; each returns the same value.
  - A write and two reads to the same address in one cycle follow the bypass rule on both ports independently.
- Width: no arithmetic; all data paths are 32 bits. Addresses are 3 bits, so every value is valid and there is no out-of-range case.
- No X propagation: every output is defined from reset onward.

Decomposition:
- Shared package regfile_pkg: REG_W=32, NREG=8, ADDR_W=3, and the constant ZERO_WORD=32'h00000000.
- Sub-module: mux8_32, instantiated twice, one per read port, unchanged.
- Port order: z, i0..i7, s.
- Bypass and zero-register override logic sits after the mux outputs inside regfile8_32.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after writing r3=32'hDEADBEEF → rd0 (ra0=3) becomes 32'h00000000 without a clk edge. Release rst_n and write nothing → rd0 stays 0.
- Write/read sweep: write r1..r7 = 32'h00000011 x index (r1=32'h11 … r7=32'h77) on consecutive edges. Then sweep ra0 and ra1 over 0..7 at 10 ns steps → rd returns 0, 32'h11, …, 32'h77. With ZERO_REG=1, r0 reads 0.
- Zero register: we=1, wa=0, wd=32'hFFFFFFFF → rd0 (ra0=0) = 0 both before and after the edge. With ZERO_REG=0 in a second elaboration → 32'hFFFFFFFF after the edge.
- Bypass, BYPASS=1: r5=32'h5, then in the same cycle we=1, wa=5, wd=32'hA5A5A5A5, ra0=5, ra1=5 → rd0=rd1=32'hA5A5A5A5 before the edge. With BYPASS=0 → 32'h5 before the edge and 32'hA5A5A5A5 after.
- we=0 hold: wd=32'h12345678, wa=2, we=0 for 4 edges → r2 unchanged at its prior value (32'h22).
- Reset vs write race: we=1, wa=4, wd=32'hCAFEF00D, rst_n=0 across the edge → r4 reads 0 after rst_n releases.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared widths and constants for the 8 x 32 register file and its read muxes.
package regfile_pkg;

    localparam int unsigned REG_W  = 32;
    localparam int unsigned NREG   = 8;
    localparam int unsigned ADDR_W = 3;

    localparam logic [REG_W-1:0] ZERO_WORD = 32'h00000000;

    // True when a write request actually lands in storage.
    function automatic logic write_kept(input logic we, input logic [ADDR_W-1:0] wa,
                                        input bit zero_reg);
        return we && !(zero_reg && (wa == '0));
    endfunction

endpackage

// File: rtl/mux8_32.sv
// 32-bit 8:1 multiplexer; s selects one of i0..i7 onto z.
module mux8_32
    import regfile_pkg::*;
(
    output logic [REG_W-1:0]  z,
    input  logic [REG_W-1:0]  i0,
    input  logic [REG_W-1:0]  i1,
    input  logic [REG_W-1:0]  i2,
    input  logic [REG_W-1:0]  i3,
    input  logic [REG_W-1:0]  i4,
    input  logic [REG_W-1:0]  i5,
    input  logic [REG_W-1:0]  i6,
    input  logic [REG_W-1:0]  i7,
    input  logic [ADDR_W-1:0] s
);

    always_comb begin
        z = i0;
        case (s)
            3'd1:    z = i1;
            3'd2:    z = i2;
            3'd3:    z = i3;
            3'd4:    z = i4;
            3'd5:    z = i5;
            3'd6:    z = i6;
            3'd7:    z = i7;
            default: z = i0;
        endcase
    end

endmodule

// File: rtl/regfile8_32.sv
// 8-entry x 32-bit register file: one synchronous write port, two combinational
// read ports, optional hardwired-zero r0 and write-to-read bypass.
module regfile8_32
    import regfile_pkg::*;
#(
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] wa,
    input  logic [REG_W-1:0]  wd,
    input  logic [ADDR_W-1:0] ra0,
    input  logic [ADDR_W-1:0] ra1,
    output logic [REG_W-1:0]  rd0,
    output logic [REG_W-1:0]  rd1
);

    logic [REG_W-1:0] regs_q [NREG];
    logic             wr_en;
    logic [REG_W-1:0] mux_z0;
    logic [REG_W-1:0] mux_z1;

    assign wr_en = write_kept(we, wa, ZERO_REG);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else if (wr_en) begin
            regs_q[wa] <= wd;
        end
    end

    mux8_32 u_mux_rd0 (
        .z  (mux_z0),
        .i0 (regs_q[0]),
        .i1 (regs_q[1]),
        .i2 (regs_q[2]),
        .i3 (regs_q[3]),
        .i4 (regs_q[4]),
        .i5 (regs_q[5]),
        .i6 (regs_q[6]),
        .i7 (regs_q[7]),
        .s  (ra0)
    );

    mux8_32 u_mux_rd1 (
        .z  (mux_z1),
        .i0 (regs_q[0]),
        .i1 (regs_q[1]),
        .i2 (regs_q[2]),
        .i3 (regs_q[3]),
        .i4 (regs_q[4]),
        .i5 (regs_q[5]),
        .i6 (regs_q[6]),
        .i7 (regs_q[7]),
        .s  (ra1)
    );

    // Reset and r0 win over bypass; bypass only follows writes that are kept.
    always_comb begin
        rd0 = mux_z0;
        if (!rst_n || (ZERO_REG && (ra0 == '0))) begin
            rd0 = ZERO_WORD;
        end else if (BYPASS && wr_en && (ra0 == wa)) begin
            rd0 = wd;
        end
    end

    always_comb begin
        rd1 = mux_z1;
        if (!rst_n || (ZERO_REG && (ra1 == '0))) begin
            rd1 = ZERO_WORD;
        end else if (BYPASS && wr_en && (ra1 == wa)) begin
            rd1 = wd;
        end
    end

endmodule

// File: tb/tb_regfile8_32.sv
// Bench for regfile8_32: two elaborations (ZERO_REG/BYPASS = 1/1 and 0/0) driven in
// parallel, checked every cycle against an array model plus literal directed checks.
module tb_regfile8_32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  wa;
    logic [31:0] wd;
    logic [2:0]  ra0;
    logic [2:0]  ra1;
    logic [31:0] rd0_a, rd1_a, rd0_b, rd1_b;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [8];

    always #5 clk = ~clk;

    regfile8_32 #(.ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra0   (ra0),
        .ra1   (ra1),
        .rd0   (rd0_a),
        .rd1   (rd1_a)
    );

    regfile8_32 #(.ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .ra0   (ra0),
        .ra1   (ra1),
        .rd0   (rd0_b),
        .rd1   (rd1_b)
    );

    // Model storage: config a never stores address 0.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                mem_a[i] <= 32'h0;
                mem_b[i] <= 32'h0;
            end
        end else if (we) begin
            if (wa != 3'd0) mem_a[wa] <= wd;
            mem_b[wa] <= wd;
        end
    end

    function automatic logic [31:0] exp_rd(input bit zr, input bit bp, input logic [2:0] ra);
        if (!rst_n) return 32'h0;
        if (zr && ra == 3'd0) return 32'h0;
        if (bp && we && ra == wa && !(zr && wa == 3'd0)) return wd;
        return zr ? mem_a[ra] : mem_b[ra];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("model rd0_a", rd0_a, exp_rd(1'b1, 1'b1, ra0));
        chk("model rd1_a", rd1_a, exp_rd(1'b1, 1'b1, ra1));
        chk("model rd0_b", rd0_b, exp_rd(1'b0, 1'b0, ra0));
        chk("model rd1_b", rd1_b, exp_rd(1'b0, 1'b0, ra1));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        we    = 1'b0;
        wa    = 3'd0;
        wd    = 32'h0;
        ra0   = 3'd3;
        ra1   = 3'd7;
        tick();
        tick();
        chk("reset rd0_a", rd0_a, 32'h0);
        chk("reset rd1_b", rd1_b, 32'h0);
        rst_n = 1'b1;

        // Asynchronous reset clears a written register between edges.
        we = 1'b1; wa = 3'd3; wd = 32'hDEADBEEF;
        tick();
        we = 1'b0; ra0 = 3'd3;
        #1 chk("r3 written a", rd0_a, 32'hDEADBEEF);
        chk("r3 written b", rd0_b, 32'hDEADBEEF);
        #1 rst_n = 1'b0;
        #1 chk("async clear a", rd0_a, 32'h0);
        chk("async clear b", rd0_b, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("after release a", rd0_a, 32'h0);
        chk("after release b", rd0_b, 32'h0);

        // Write r1..r7 = 0x11 * index, then sweep both read ports.
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; wa = 3'(i); wd = 32'(i) * 32'h11;
            tick();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra0 = 3'(i); ra1 = 3'(7 - i);
            #1 chk("sweep rd0_a", rd0_a, 32'(i) * 32'h11);
            chk("sweep rd1_a", rd1_a, 32'(7 - i) * 32'h11);
            chk("sweep rd0_b", rd0_b, 32'(i) * 32'h11);
            tick();
        end

        // Write to address 0.
        we = 1'b1; wa = 3'd0; wd = 32'hFFFFFFFF; ra0 = 3'd0;
        #1 chk("r0 before a", rd0_a, 32'h0);
        chk("r0 before b", rd0_b, 32'h0);
        tick();
        we = 1'b0;
        #1 chk("r0 after a", rd0_a, 32'h0);
        chk("r0 after b", rd0_b, 32'hFFFFFFFF);

        // Bypass on both ports.
        tick();
        we = 1'b1; wa = 3'd5; wd = 32'h5;
        tick();
        wd = 32'hA5A5A5A5; ra0 = 3'd5; ra1 = 3'd5;
        #1 chk("bypass rd0_a", rd0_a, 32'hA5A5A5A5);
        chk("bypass rd1_a", rd1_a, 32'hA5A5A5A5);
        chk("no bypass rd0_b", rd0_b, 32'h5);
        chk("no bypass rd1_b", rd1_b, 32'h5);
        tick();
        we = 1'b0;
        #1 chk("post edge rd0_b", rd0_b, 32'hA5A5A5A5);

        // we=0 holds r2.
        wa = 3'd2; wd = 32'h12345678; ra0 = 3'd2;
        repeat (4) tick();
        chk("hold r2 a", rd0_a, 32'h22);
        chk("hold r2 b", rd0_b, 32'h22);

        // Write lost when reset is low across the edge.
        we = 1'b1; wa = 3'd4; wd = 32'hCAFEF00D; ra0 = 3'd4;
        #2 rst_n = 1'b0;
        tick();
        we = 1'b0; rst_n = 1'b1;
        #1 chk("race r4 a", rd0_a, 32'h0);
        chk("race r4 b", rd0_b, 32'h0);

        // Random traffic with read addresses biased toward the write address.
        for (int n = 0; n < 1500; n++) begin
            tick();
            rst_n = 1'b1;
            we  = 1'($urandom_range(0, 1));
            wa  = 3'($urandom_range(0, 7));
            wd  = $urandom;
            ra0 = ($urandom_range(0, 1) == 1) ? wa : 3'($urandom_range(0, 7));
            ra1 = ($urandom_range(0, 1) == 1) ? wa : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 63) == 0) begin
                #2 rst_n = 1'b0;
            end
        end
        tick();
        rst_n = 1'b1;
        we = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
